mmsa_out_serializer: RTL
========================

# mmsa_out_serializer

Downstream output stage of the MMSA matrix-multiply datapath. Accepts parallel result words from the systolic array's result drain through a valid/ready handshake, buffers up to two words, and emits each word on the 1-bit `out_value` line as a self-delimiting frame: a 6-bit bit-length field followed by exactly that many value bits, both MSB-first. `out_valid` and `out_value` are the chip-level output pins.

## Interface
- `DATA_W`, 40: result word width; unsigned.
- `LEN_W`, 6: length-field width; must satisfy 2^LEN_W > DATA_W.
- `DEPTH`, 2: input FIFO entries.

- `clk`  in  1  sole clock; all logic on the rising edge.
- `rst_n`  in  1  synchronous, active-high reset (port name kept for pin compatibility); 1 = reset at the next rising edge.
- `res_valid`  in  1  result word offered.
- `res_data`  in  DATA_W  result word, unsigned.
- `res_ready`  out  1  FIFO can accept; transfer on `res_valid & res_ready` at a rising edge.
- `out_valid`  out  1  `out_value` carries a frame bit this cycle.
- `out_value`  out  1  serial frame bit.
- `busy`  out  1  FIFO non-empty or frame in progress.

## Operation
- Length L = index of the highest set bit + 1; a value of 0 gives L = 1. Range 1..DATA_W.
- Frame = L on LEN_W bits, MSB-first, then res_data[L-1:0], MSB-first. Frame length = LEN_W + L cycles.
- FIFO is first-word fall-through with DEPTH entries. `res_ready = (count < DEPTH)`, driven from registered count only. When full, a same-cycle pop does not raise `res_ready`; there is no bypass.
- FSM states:
  - IDLE: `out_valid = 0`. If the FIFO is non-empty, pop the head, load the length and value shift registers, and go to LEN.
  - LEN: emit length bits. After LEN_W bits, go to VAL.
  - VAL: emit value bits. On the last bit, if the FIFO is non-empty, pop and reload, then go to LEN with no bubble. Otherwise go to IDLE.
- Push and pop in the same cycle are legal when not full; count is unchanged.
- `out_value = 0` whenever `out_valid = 0`.
- `busy = (count != 0) | (state != IDLE)`.
- If `res_valid` is high while `res_ready` is low, the word is not taken. The upstream stage must hold the word.

## Timing
- Reset values: `out_valid = 0`, `out_value = 0`, `res_ready = 1`, `busy = 0`.
- On reset, FIFO count = 0 and state = IDLE. Reset mid-frame truncates the frame: outputs are 0 from the reset edge onward, and no remaining bits are emitted after reset deasserts.
- Latency: a word accepted at edge E into an empty, idle block has its first length bit (`out_valid = 1`) from edge E+1.
- During a frame, `out_valid` is continuous for exactly LEN_W + L cycles.
- Back-to-back: the next frame's first bit follows the previous frame's last bit on the very next cycle when the FIFO is non-empty.
- Throughput: at most one word per LEN_W + 1 cycles (at L = 1). The upstream stage sees backpressure via `res_ready`.
- Length and shift-register loads are registered; the leading-one detect is combinational from the FIFO head. Its depth is log2(DATA_W) levels.

## Structure
- Package `mmsa_pkg` holds:
  - constants DATA_W = 40 and LEN_W = 6;
  - the state enum `ser_state_t` {IDLE, LEN, VAL};
  - `len_t` = logic [LEN_W-1:0].
- Sub-module `mmsa_lead_one` takes DATA_W bits and produces the L value (0 maps to 1), combinational, parameterised by DATA_W. FIFO and FSM stay in the top module.

## Test plan
- Reset, then one word `res_data = 5`: L = 3. Frame is `000011` then `101` (9 cycles). `out_valid` rises the edge after acceptance, then `busy` falls.
- Word `0`: frame `000001` then `0`, 7 cycles. Word `2^39` (bit 39 only): L = 40. Frame is `101000` then `1` followed by 39 zeros, 46 cycles.
- Burst of 4 words (1, 3, 7, 15) with `res_valid` held high:
  - `res_ready` drops after 2 are stored;
  - the 4 frames come out with no `out_valid` gaps: `000001 1`, `000010 11`, `000011 111`, `000100 1111`;
  - all words are accepted in order.
- FIFO full with `res_valid` high on the same edge as a pop: the word is not accepted that cycle and is accepted on the next edge.
- Assert reset in the 3rd cycle of a frame for word `0xFF`:
  - `out_valid = 0` from the reset edge;
  - after release, with no new input, `out_valid` stays 0 and `res_ready = 1`.
- Random 2000 words with random `res_valid` gaps: a scoreboard decodes the serial stream (read LEN_W bits, then L bits) and matches the input order exactly.

Source files
------------

// File: rtl/mmsa_pkg.sv
// Shared constants and types for the MMSA output serializer.
package mmsa_pkg;

    localparam int DATA_W = 40;
    localparam int LEN_W  = 6;

    typedef enum logic [1:0] {
        IDLE,
        LEN,
        VAL
    } ser_state_t;

    typedef logic [LEN_W-1:0] len_t;

endpackage

// File: rtl/mmsa_lead_one.sv
// Leading-one detector: returns the bit length of a word (a zero word counts as length 1).
module mmsa_lead_one #(
    parameter int DATA_W = mmsa_pkg::DATA_W,
    parameter int LEN_W  = mmsa_pkg::LEN_W
) (
    input  logic [DATA_W-1:0] data,
    output logic [LEN_W-1:0]  len
);
    import mmsa_pkg::*;

    // Highest set bit wins; the loop flattens into a priority encoder tree.
    always_comb begin
        len = LEN_W'(1);
        for (int i = 0; i < DATA_W; i++) begin
            if (data[i]) begin
                len = LEN_W'(i + 1);
            end
        end
    end

endmodule

// File: rtl/mmsa_out_serializer.sv
// Output stage: small FWFT FIFO feeding a length-prefixed, MSB-first serial framer.
module mmsa_out_serializer #(
    parameter int DATA_W = mmsa_pkg::DATA_W,
    parameter int LEN_W  = mmsa_pkg::LEN_W,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              res_valid,
    input  logic [DATA_W-1:0] res_data,
    output logic              res_ready,
    output logic              out_valid,
    output logic              out_value,
    output logic              busy
);
    import mmsa_pkg::*;

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] fifo_mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;
    logic              push;
    logic              pop;
    logic [DATA_W-1:0] head;
    logic [LEN_W-1:0]  head_len;
    logic [LEN_W-1:0]  shift_amt;

    ser_state_t        state;
    ser_state_t        next_state;
    logic [LEN_W-1:0]  len_sr;
    logic [LEN_W-1:0]  cur_len;
    logic [LEN_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] val_sr;

    // Ready comes only from the registered count, so a pop never opens a slot in the same cycle.
    assign res_ready = (count < CNT_W'(DEPTH));
    assign push      = res_valid & res_ready;
    assign head      = fifo_mem[rd_ptr];
    assign shift_amt = LEN_W'(DATA_W) - head_len;
    assign busy      = (count != '0) | (state != IDLE);

    mmsa_lead_one #(
        .DATA_W (DATA_W),
        .LEN_W  (LEN_W)
    ) u_lead_one (
        .data (head),
        .len  (head_len)
    );

    // FIFO storage; contents are don't-care until written, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= res_data;
        end
    end

    // FIFO pointers and occupancy; a simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Framer state register.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and pop decision; the last value bit chains straight into the next frame.
    always_comb begin
        next_state = state;
        pop        = 1'b0;
        unique case (state)
            IDLE: begin
                if (count != '0) begin
                    pop        = 1'b1;
                    next_state = LEN;
                end
            end
            LEN: begin
                if (bit_cnt == '0) begin
                    next_state = VAL;
                end
            end
            VAL: begin
                if (bit_cnt == '0) begin
                    if (count != '0) begin
                        pop        = 1'b1;
                        next_state = LEN;
                    end else begin
                        next_state = IDLE;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Shift registers: value is MSB-aligned on load so both fields shift out of the top bit.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            len_sr  <= '0;
            cur_len <= '0;
            val_sr  <= '0;
            bit_cnt <= '0;
        end else if (pop) begin
            len_sr  <= head_len;
            cur_len <= head_len;
            val_sr  <= head << shift_amt;
            bit_cnt <= LEN_W'(LEN_W - 1);
        end else if (state == LEN) begin
            len_sr  <= len_sr << 1;
            bit_cnt <= (bit_cnt == '0) ? cur_len - 1'b1 : bit_cnt - 1'b1;
        end else if (state == VAL) begin
            val_sr  <= val_sr << 1;
            bit_cnt <= bit_cnt - 1'b1;
        end
    end

    // Serial outputs; the data line is held low whenever no frame bit is present.
    always_comb begin
        out_valid = 1'b0;
        out_value = 1'b0;
        unique case (state)
            LEN: begin
                out_valid = 1'b1;
                out_value = len_sr[LEN_W-1];
            end
            VAL: begin
                out_valid = 1'b1;
                out_value = val_sr[DATA_W-1];
            end
            default: begin
                out_valid = 1'b0;
                out_value = 1'b0;
            end
        endcase
    end

endmodule
